// File: rtl/id_pkg.sv
// Shared definitions for the instruction-decode stage: default widths,
// decode FSM states and the opcode class that marks a two-word instruction.
package id_pkg;

  localparam int DEF_IW    = 16;
  localparam int DEF_DW    = 16;
  localparam int DEF_NREG  = 8;
  localparam int DEF_OPC_W = 5;
  localparam int DEF_SH_W  = 8;

  // The top CLASS_W opcode bits select the instruction class.
  localparam int          CLASS_W        = 2;
  localparam logic [1:0]  TWO_WORD_CLASS = 2'b10;

  typedef enum logic [0:0] {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_bypass.sv
// Register file with two combinational read ports, one write port and
// write-through bypass so a same-cycle write-back is visible to readers.
module regfile_bypass #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic [DW-1:0] rd_data1,
  output logic [DW-1:0] rd_data2
);

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data1 = (wr_en && (wr_addr == rd_addr1)) ? wr_data : regs[rd_addr1];
  assign rd_data2 = (wr_en && (wr_addr == rd_addr2)) ? wr_data : regs[rd_addr2];

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: field extraction, two-word instruction sequencing,
// register read with write-back bypass, and the ID/EX pipeline register.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int IW    = DEF_IW,
  parameter int DW    = DEF_DW,
  parameter int NREG  = DEF_NREG,
  parameter int AW    = $clog2(NREG),
  parameter int OPC_W = DEF_OPC_W,
  parameter int SH_W  = DEF_SH_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [IW-1:0]    instr,
  input  logic             stall,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [DW-1:0]    wb_data,
  output logic             fetch_hold,
  output logic             ex_valid,
  output logic [OPC_W-1:0] ex_opcode,
  output logic [DW-1:0]    ex_rs1_data,
  output logic [DW-1:0]    ex_rs2_data,
  output logic [AW-1:0]    ex_rd_addr,
  output logic [DW-1:0]    ex_imm,
  output logic             ex_has_imm,
  output logic [SH_W-1:0]  ex_shamt
);

  localparam int RS1_MSB = IW - OPC_W - 1;
  localparam int RS2_MSB = IW - OPC_W - AW - 1;

  state_e           state;
  logic [OPC_W-1:0] hold_opcode;
  logic [AW-1:0]    hold_rs1;
  logic [AW-1:0]    hold_rs2;
  logic [SH_W-1:0]  hold_shamt;

  logic [OPC_W-1:0] f_opcode;
  logic [AW-1:0]    f_rs1;
  logic [AW-1:0]    f_rs2;
  logic [SH_W-1:0]  f_shamt;
  logic             f_two_word;

  logic [AW-1:0]    rd_addr1;
  logic [AW-1:0]    rd_addr2;
  logic [DW-1:0]    rd_data1;
  logic [DW-1:0]    rd_data2;

  assign f_opcode   = instr[IW-1 -: OPC_W];
  assign f_rs1      = instr[RS1_MSB -: AW];
  assign f_rs2      = instr[RS2_MSB -: AW];
  assign f_shamt    = instr[SH_W-1:0];
  assign f_two_word = (instr[IW-1 -: CLASS_W] == TWO_WORD_CLASS);

  // While waiting for the immediate word, operands come from the latched
  // addresses so that write-backs during the wait are picked up.
  assign rd_addr1 = (state == S_IMM) ? hold_rs1 : f_rs1;
  assign rd_addr2 = (state == S_IMM) ? hold_rs2 : f_rs2;

  assign fetch_hold = stall;

  regfile_bypass #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wb_en),
    .wr_addr  (wb_addr),
    .wr_data  (wb_data),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2)
  );

  // Priority: reset, then flush, then stall, then normal sequencing.
  // Bubbles zero the whole EX register rather than leaving stale fields.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state       <= S_OP;
      hold_opcode <= '0;
      hold_rs1    <= '0;
      hold_rs2    <= '0;
      hold_shamt  <= '0;
      ex_valid    <= 1'b0;
      ex_opcode   <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_rd_addr  <= '0;
      ex_imm      <= '0;
      ex_has_imm  <= 1'b0;
      ex_shamt    <= '0;
    end else if (!stall) begin
      ex_valid    <= 1'b0;
      ex_opcode   <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_rd_addr  <= '0;
      ex_imm      <= '0;
      ex_has_imm  <= 1'b0;
      ex_shamt    <= '0;
      case (state)
        S_OP: begin
          if (instr_valid && f_two_word) begin
            hold_opcode <= f_opcode;
            hold_rs1    <= f_rs1;
            hold_rs2    <= f_rs2;
            hold_shamt  <= f_shamt;
            state       <= S_IMM;
          end else if (instr_valid) begin
            ex_valid    <= 1'b1;
            ex_opcode   <= f_opcode;
            ex_rs1_data <= rd_data1;
            ex_rs2_data <= rd_data2;
            ex_rd_addr  <= f_rs2;
            ex_shamt    <= f_shamt;
          end
        end
        S_IMM: begin
          if (instr_valid) begin
            ex_valid    <= 1'b1;
            ex_opcode   <= hold_opcode;
            ex_rs1_data <= rd_data1;
            ex_rs2_data <= rd_data2;
            ex_rd_addr  <= hold_rs2;
            ex_shamt    <= hold_shamt;
            ex_imm      <= DW'(instr);
            ex_has_imm  <= 1'b1;
            state       <= S_OP;
          end
        end
        default: state <= S_OP;
      endcase
    end
  end

endmodule
